// File: rtl/seg7_adder_scan.sv
// Registered adder (2-edge latency) whose result is shown on a multiplexed
// hex 7-segment display, with leading-zero blanking and selectable polarity.
module seg7_adder_scan #(
  parameter int WIDTH      = 8,
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 16,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic              cin,
  input  logic              mode,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              Overflow,
  output logic              valid
);

  localparam int DISP_W = 4 * DIGITS;
  localparam int CNT_W  = $clog2(SCAN_DIV);
  localparam int IDX_W  = $clog2(DIGITS);

  logic [WIDTH-1:0]  a_q, b_q;
  logic              cin_q, mode_q, pend_q;
  logic [DISP_W-1:0] disp_q, disp_d;
  logic              ovf_q, ovf_d;
  logic              valid_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  digit_q, digit_d;
  logic [WIDTH:0]    sum_d;
  logic [DISP_W-1:0] shifted;
  logic [6:0]        seg_raw;
  logic [DIGITS-1:0] an_raw;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0:    hex7 = 7'h3F;
      4'h1:    hex7 = 7'h06;
      4'h2:    hex7 = 7'h5B;
      4'h3:    hex7 = 7'h4F;
      4'h4:    hex7 = 7'h66;
      4'h5:    hex7 = 7'h6D;
      4'h6:    hex7 = 7'h7D;
      4'h7:    hex7 = 7'h07;
      4'h8:    hex7 = 7'h7F;
      4'h9:    hex7 = 7'h6F;
      4'hA:    hex7 = 7'h77;
      4'hB:    hex7 = 7'h7C;
      4'hC:    hex7 = 7'h39;
      4'hD:    hex7 = 7'h5E;
      4'hE:    hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // Signed mode shows only the WIDTH-bit sum; unsigned mode keeps the carry nibble.
  always_comb begin
    sum_d = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
    if (mode_q) begin
      disp_d = DISP_W'(sum_d[WIDTH-1:0]);
      ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
    end else begin
      disp_d = DISP_W'(sum_d);
      ovf_d  = sum_d[WIDTH];
    end
  end

  // NOTE: every signal written in a combinational block gets a default first so no latch is inferred.
  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    digit_d = digit_q;
    if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_d   = '0;
      digit_d = (digit_q == IDX_W'(DIGITS - 1)) ? '0 : digit_q + IDX_W'(1);
    end
  end

  // Decoding straight from digit_q keeps an and seg switching on the same edge.
  always_comb begin
    shifted = disp_q >> {digit_q, 2'b00};
    seg_raw = hex7(shifted[3:0]);
    if (!valid_q || ((digit_q != '0) && (shifted == '0))) begin
      seg_raw = '0;
    end
    an_raw = DIGITS'(1) << digit_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      mode_q  <= 1'b0;
      pend_q  <= 1'b0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      digit_q <= '0;
    end else begin
      if (load) begin
        a_q    <= A;
        b_q    <= B;
        cin_q  <= cin;
        mode_q <= mode;
      end
      pend_q <= load;
      if (pend_q) begin
        disp_q  <= disp_d;
        ovf_q   <= ovf_d;
        valid_q <= 1'b1;
      end
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
    end
  end

  assign seg      = (ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
  assign an       = (ACTIVE_LOW != 0) ? ~an_raw  : an_raw;
  assign Overflow = ovf_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_seg7_adder_scan.sv
// Scoreboard bench: loads push expected results, a monitor pops them when due
// and compares both polarity builds against an arithmetic display model.
module tb_seg7_adder_scan;

  localparam int WIDTH    = 8;
  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 16;

  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct {
    int value;
    bit ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, load, cin, mode;
  logic [WIDTH-1:0] a, b;
  logic [6:0]       seg_l, seg_h;
  logic [3:0]       an_l, an_h;
  logic             ovf_l, ovf_h, valid_l, valid_h;

  seg7_adder_scan #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .ACTIVE_LOW(1)) dut_lo (
    .clk(clk), .rst_n(rst_n), .load(load), .A(a), .B(b), .cin(cin), .mode(mode),
    .seg(seg_l), .an(an_l), .Overflow(ovf_l), .valid(valid_l)
  );

  seg7_adder_scan #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .ACTIVE_LOW(0)) dut_hi (
    .clk(clk), .rst_n(rst_n), .load(load), .A(a), .B(b), .cin(cin), .mode(mode),
    .seg(seg_h), .an(an_h), .Overflow(ovf_h), .valid(valid_h)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  function automatic exp_t ref_model(input int ra, input int rb, input int rc, input int rm);
    exp_t e;
    int   s, sa, sb, ss;
    s = ra + rb + rc;
    if (rm != 0) begin
      sa = (ra > 127) ? ra - 256 : ra;
      sb = (rb > 127) ? rb - 256 : rb;
      ss = sa + sb + rc;
      e.value = s % 256;
      e.ovf   = (ss > 127) || (ss < -128);
    end else begin
      e.value = s;
      e.ovf   = (s > 255);
    end
    return e;
  endfunction

  // Called at a falling edge; leaves load low one cycle later.
  task automatic drive_load(input int ta, input int tb_v, input int tc, input int tm);
    a    = WIDTH'(ta);
    b    = WIDTH'(tb_v);
    cin  = tc[0];
    mode = tm[0];
    load = 1'b1;
    if (rst_n) sb_q.push_back(ref_model(ta, tb_v, tc, tm));
    @(negedge clk);
    load = 1'b0;
  endtask

  // Monitor: result model advanced on rising edges, outputs compared on falling edges.
  bit         m_seen  = 1'b0;
  bit         m_pend  = 1'b0;
  bit         m_valid = 1'b0;
  bit         m_ovf   = 1'b0;
  int         m_val   = 0;
  int         m_k     = 0;
  int         d, up;
  logic [3:0] e_an, e_an_n;
  logic [6:0] e_seg, e_seg_n;
  exp_t       e;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_seen = 1'b1; m_pend = 1'b0; m_valid = 1'b0; m_ovf = 1'b0; m_val = 0; m_k = 0;
        sb_q.delete();
      end else if (m_seen) begin
        m_k++;
        if (m_pend) begin
          if (sb_q.size() == 0) begin
            check("scoreboard_underflow", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            m_val = e.value; m_ovf = e.ovf; m_valid = 1'b1;
          end
        end
        m_pend = load;
      end
      @(negedge clk);
      if (m_seen) begin
        d     = (m_k / SCAN_DIV) % DIGITS;
        e_an  = 4'(1 << d);
        e_seg = 7'h00;
        if (m_valid) begin
          up = m_val >> (4 * d);
          if ((d == 0) || (up != 0)) e_seg = GLYPH[up % 16];
        end
        e_an_n  = ~e_an;
        e_seg_n = ~e_seg;
        check("an_lo",     32'(an_l),    32'(e_an_n));
        check("seg_lo",    32'(seg_l),   32'(e_seg_n));
        check("an_hi",     32'(an_h),    32'(e_an));
        check("seg_hi",    32'(seg_h),   32'(e_seg));
        check("an_onehot", 32'($onehot(an_h)), 32'd1);
        check("valid_lo",  32'(valid_l), 32'(m_valid));
        check("valid_hi",  32'(valid_h), 32'(m_valid));
        check("ovf_lo",    32'(ovf_l),   32'(m_ovf));
        check("ovf_hi",    32'(ovf_h),   32'(m_ovf));
      end
    end
  end

  initial begin
    int gap;
    rst_n = 1'b0; load = 1'b0; a = '0; b = '0; cin = 1'b0; mode = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    drive_load(8'hFF, 8'h01, 0, 0);          // 0x100, carry out
    repeat (80) @(negedge clk);
    drive_load(8'h7F, 8'h01, 1, 1);          // "81", signed overflow
    repeat (70) @(negedge clk);
    drive_load(8'hF0, 8'hF0, 0, 1);          // "E0", carry ignored
    repeat (70) @(negedge clk);
    drive_load(8'h12, 8'h01, 0, 0);          // back-to-back, last wins
    drive_load(8'h20, 8'h02, 0, 0);
    repeat (70) @(negedge clk);
    drive_load(8'h00, 8'h00, 0, 0);          // single "0"
    repeat (70) @(negedge clk);

    // Reset mid-frame together with a load: nothing may be captured.
    repeat (7) @(negedge clk);
    rst_n = 1'b0; load = 1'b1; a = 8'h55; b = 8'h66; cin = 1'b1; mode = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; load = 1'b0;
    repeat (70) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      drive_load($urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 1), $urandom_range(0, 1));
      gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 40);
      if (i == 20) begin
        rst_n = 1'b0; load = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; load = 1'b0;
      end
      repeat (gap) @(negedge clk);
    end

    repeat (4 * SCAN_DIV * DIGITS) @(negedge clk);

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
